fetch_stage: RTL and testbench

//   Instruction-fetch stage with IF/ID pipeline register. It holds the PC and

---
 rtl/fetch_stage.sv | 81 ++++++++
 tb/tb_fetch_stage.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, requests to a 1-cycle synchronous imem, IF/ID register,
// hazard stall with a 1-entry hold buffer, and branch redirect/flush.
module fetch_stage #(
  parameter int unsigned        DATA_W   = 32,
  parameter logic [DATA_W-1:0]  PC_RESET = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [DATA_W-1:0] branch_target,
  output logic              imem_req,
  output logic [DATA_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              if_id_valid,
  output logic [DATA_W-1:0] if_id_instr,
  output logic [DATA_W-1:0] if_id_pc,
  output logic [DATA_W-1:0] if_id_pc4
);

  logic [DATA_W-1:0] pc_q;
  logic              inflight_q;
  logic [DATA_W-1:0] inflight_pc_q;
  logic              hold_valid_q;
  logic [DATA_W-1:0] hold_instr_q;
  logic [DATA_W-1:0] hold_pc_q;

  assign imem_req  = !stall && !branch_taken && !reset;
  assign imem_addr = pc_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q          <= PC_RESET;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      hold_valid_q  <= 1'b0;
      hold_instr_q  <= '0;
      hold_pc_q     <= '0;
      if_id_valid   <= 1'b0;
      if_id_instr   <= '0;
      if_id_pc      <= '0;
      if_id_pc4     <= '0;
    end else if (branch_taken) begin
      // Masking the whole target keeps every bit of the port in use.
      pc_q         <= branch_target & ~DATA_W'(3);
      inflight_q   <= 1'b0;
      hold_valid_q <= 1'b0;
      if_id_valid  <= 1'b0;
    end else if (stall) begin
      inflight_q <= 1'b0;
      if (inflight_q) begin
        hold_valid_q <= 1'b1;
        hold_instr_q <= imem_rdata;
        hold_pc_q    <= inflight_pc_q;
      end
    end else begin
      inflight_q    <= 1'b1;
      inflight_pc_q <= pc_q;
      pc_q          <= pc_q + DATA_W'(4);
      if (hold_valid_q) begin
        hold_valid_q <= 1'b0;
        if_id_valid  <= 1'b1;
        if_id_instr  <= hold_instr_q;
        if_id_pc     <= hold_pc_q;
        if_id_pc4    <= hold_pc_q + DATA_W'(4);
      end else if (inflight_q) begin
        if_id_valid  <= 1'b1;
        if_id_instr  <= imem_rdata;
        if_id_pc     <= inflight_pc_q;
        if_id_pc4    <= inflight_pc_q + DATA_W'(4);
      end else begin
        if_id_valid  <= 1'b0;
      end
    end
  end

  // A returning word must never meet an occupied hold buffer.
  hold_inflight_exclusive: assert property (@(posedge clk) disable iff (reset)
    !(hold_valid_q && inflight_q));

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: streaming, stall/hold, redirect, redirect over stall,
// PC wrap (second instance) and asynchronous reset with a full hold buffer.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset, stall, branch_taken;
  logic [31:0] branch_target;
  logic        imem_req;
  logic [31:0] imem_addr, imem_rdata;
  logic        if_id_valid;
  logic [31:0] if_id_instr, if_id_pc, if_id_pc4;

  logic        reset2;
  logic        stall2 = 1'b0;
  logic        branch2 = 1'b0;
  logic [31:0] target2 = 32'h0;
  logic        imem_req2;
  logic [31:0] imem_addr2, imem_rdata2;
  logic        if_id_valid2;
  logic [31:0] if_id_instr2, if_id_pc2, if_id_pc42;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .if_id_valid(if_id_valid), .if_id_instr(if_id_instr),
    .if_id_pc(if_id_pc), .if_id_pc4(if_id_pc4)
  );

  fetch_stage #(.PC_RESET(32'hFFFF_FFF8)) dut_wrap (
    .clk(clk), .reset(reset2), .stall(stall2), .branch_taken(branch2),
    .branch_target(target2), .imem_req(imem_req2), .imem_addr(imem_addr2),
    .imem_rdata(imem_rdata2), .if_id_valid(if_id_valid2), .if_id_instr(if_id_instr2),
    .if_id_pc(if_id_pc2), .if_id_pc4(if_id_pc42)
  );

  function automatic logic [31:0] wrd(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  // Synchronous instruction memory; junk when no request so stale reuse is visible.
  always @(posedge clk) begin
    imem_rdata  <= imem_req  ? wrd(imem_addr)  : 32'hBAD0_BAD0;
    imem_rdata2 <= imem_req2 ? wrd(imem_addr2) : 32'hBAD0_BAD0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; reset2 = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
    #1;
    chk("rst valid", 32'(if_id_valid), 32'd0);
    chk("rst instr", if_id_instr, 32'h0);
    chk("rst pc", if_id_pc, 32'h0);
    chk("rst pc4", if_id_pc4, 32'h0);
    chk("rst req", 32'(imem_req), 32'd0);

    // 1: free-running stream
    @(negedge clk); reset = 1'b0; #1;
    chk("t1 req", 32'(imem_req), 32'd1);
    chk("t1 addr0", imem_addr, 32'h0);
    step();
    chk("t1 bubble", 32'(if_id_valid), 32'd0);
    chk("t1 addr4", imem_addr, 32'h4);
    step();
    chk("t1 valid", 32'(if_id_valid), 32'd1);
    chk("t1 pc0", if_id_pc, 32'h0);
    chk("t1 instr0", if_id_instr, wrd(32'h0));
    chk("t1 pc4", if_id_pc4, 32'h4);
    chk("t1 addr8", imem_addr, 32'h8);
    step();
    chk("t1 pc4b", if_id_pc, 32'h4);
    chk("t1 instr4", if_id_instr, wrd(32'h4));
    chk("t1 addr12", imem_addr, 32'hC);

    // 2: stall three cycles with word@8 in flight
    stall = 1'b1; #1;
    chk("t2 req off", 32'(imem_req), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t2 hold pc", if_id_pc, 32'h4);
      chk("t2 hold valid", 32'(if_id_valid), 32'd1);
      chk("t2 req off", 32'(imem_req), 32'd0);
      chk("t2 addr", imem_addr, 32'hC);
    end
    stall = 1'b0; #1;
    chk("t2 req on", 32'(imem_req), 32'd1);
    step();
    chk("t2 pc8", if_id_pc, 32'h8);
    chk("t2 instr8", if_id_instr, wrd(32'h8));
    chk("t2 pc4", if_id_pc4, 32'hC);
    chk("t2 addr16", imem_addr, 32'h10);
    step();
    chk("t2 pc12", if_id_pc, 32'hC);
    chk("t2 instr12", if_id_instr, wrd(32'hC));

    // 3: redirect while word@16 is returning
    branch_taken = 1'b1; branch_target = 32'h0000_0103; #1;
    chk("t3 req off", 32'(imem_req), 32'd0);
    step();
    branch_taken = 1'b0; #1;
    chk("t3 bubble1", 32'(if_id_valid), 32'd0);
    chk("t3 addr", imem_addr, 32'h100);
    step();
    chk("t3 bubble2", 32'(if_id_valid), 32'd0);
    step();
    chk("t3 valid", 32'(if_id_valid), 32'd1);
    chk("t3 pc", if_id_pc, 32'h100);
    chk("t3 instr", if_id_instr, wrd(32'h100));
    chk("t3 pc4", if_id_pc4, 32'h104);

    // 4: redirect and stall together with the hold buffer full
    stall = 1'b1;
    step();
    chk("t4 stall pc", if_id_pc, 32'h100);
    branch_taken = 1'b1; branch_target = 32'h0000_0200;
    step();
    stall = 1'b0; branch_taken = 1'b0; #1;
    chk("t4 flushed", 32'(if_id_valid), 32'd0);
    chk("t4 addr", imem_addr, 32'h200);
    step();
    chk("t4 no stale", 32'(if_id_valid), 32'd0);
    step();
    chk("t4 valid", 32'(if_id_valid), 32'd1);
    chk("t4 pc", if_id_pc, 32'h200);
    chk("t4 instr", if_id_instr, wrd(32'h200));

    // 6: asynchronous reset mid-stall with the hold buffer full
    stall = 1'b1;
    step();
    #2 reset = 1'b1; #1;
    chk("t6 valid", 32'(if_id_valid), 32'd0);
    chk("t6 instr", if_id_instr, 32'h0);
    chk("t6 pc", if_id_pc, 32'h0);
    chk("t6 pc4", if_id_pc4, 32'h0);
    chk("t6 addr", imem_addr, 32'h0);
    @(negedge clk); reset = 1'b0; stall = 1'b0; #1;
    chk("t6 req", 32'(imem_req), 32'd1);
    step();
    chk("t6 bubble", 32'(if_id_valid), 32'd0);
    step();
    chk("t6 valid", 32'(if_id_valid), 32'd1);
    chk("t6 restart pc", if_id_pc, 32'h0);
    chk("t6 restart instr", if_id_instr, wrd(32'h0));

    // 5: address wrap from a high PC_RESET
    reset2 = 1'b0; #1;
    chk("t5 addr", imem_addr2, 32'hFFFF_FFF8);
    chk("t5 req", 32'(imem_req2), 32'd1);
    step();
    chk("t5 bubble", 32'(if_id_valid2), 32'd0);
    step();
    chk("t5 pcF8", if_id_pc2, 32'hFFFF_FFF8);
    chk("t5 pc4F8", if_id_pc42, 32'hFFFF_FFFC);
    chk("t5 addr wrap", imem_addr2, 32'h0);
    step();
    chk("t5 pcFC", if_id_pc2, 32'hFFFF_FFFC);
    chk("t5 pc4FC", if_id_pc42, 32'h0);
    step();
    chk("t5 pc0", if_id_pc2, 32'h0);
    chk("t5 pc4 0", if_id_pc42, 32'h4);
    chk("t5 instr0", if_id_instr2, wrd(32'h0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
